blink_code_ctrl: RTL and testbench
==================================

BLINK_CODE_CTRL -- requirements
Module: blink_code_ctrl

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 1000, clocks per timing unit (>=1).
REQ-002 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port code_valid_i  input  1  blink-code request valid.
REQ-005 SHALL have port code_ready_o  output  1  controller idle, can accept a code.
REQ-006 SHALL have port code_pulses_i  input  4  pulses in code, 0..15.
REQ-007 SHALL have port code_on_i  input  8  on-phase length, units.
REQ-008 SHALL have port code_off_i  input  8  inter-pulse off length, units.
REQ-009 SHALL have port code_gap_i  input  8  trailing gap after last pulse, units.
REQ-010 SHALL have port abort_i  input  1  cancel current code.
REQ-011 SHALL have port led_o  output  1  LED drive, 1 = on.
REQ-012 SHALL have port busy_o  output  1  code in progress (= !code_ready_o).
REQ-013 SHALL have port done_o  output  1  one-cycle pulse on normal code completion.

Function
REQ-014 SHALL implement states IDLE, ON, OFF, GAP; code_ready_o = 1 only in IDLE.
REQ-015 SHALL accept a code on a rising edge with code_valid_i && code_ready_o && !abort_i, registering pulses/on/off/gap; inputs are ignored thereafter until IDLE.
REQ-016 SHALL treat any 0 on/off/gap unit field as 1 unit.
REQ-017 SHALL on acceptance with pulses >= 1 enter ON; led_o = 1 from the next cycle.
REQ-018 SHALL hold every phase exactly units*UNIT_CYCLES clocks, using a prescaler and unit counter both cleared on every state entry.
REQ-019 SHALL leave ON for OFF if pulses remain after the current one, else for GAP.
REQ-020 SHALL leave OFF for ON, decrementing the remaining-pulse count.
REQ-021 SHALL drive led_o = 1 only in ON; 0 in IDLE, OFF, GAP.
REQ-022 SHALL leave GAP for IDLE, asserting done_o for exactly the first IDLE cycle; code_ready_o is 1 that same cycle.
REQ-023 SHALL on acceptance with pulses = 0 enter GAP directly (LED stays off), then complete per REQ-022.
REQ-024 SHALL on abort_i = 1 in any non-IDLE state go to IDLE next cycle: led_o = 0, counters cleared, no done_o.
REQ-025 SHALL give abort_i priority over code_valid_i in IDLE (no acceptance); abort_i in IDLE otherwise has no effect.
REQ-026 SHALL size the prescaler as $clog2(UNIT_CYCLES) bits (minimum 1); the unit counter is 8 bits with no overflow possible.
REQ-027 SHALL support back-to-back codes: valid held high during done_o cycle is accepted on that edge.

Reset
REQ-028 SHALL on rst_i assertion immediately (asynchronously) force IDLE, led_o = 0, done_o = 0, busy_o = 0, code_ready_o = 1, all counters and registered fields to 0.
REQ-029 SHALL, with rst_i asserted mid-code, drop led_o without waiting for a clock edge and require a new handshake after release.

Verification (bench uses UNIT_CYCLES = 4)
REQ-030 SHALL verify pulses=3, on=2, off=1, gap=3: led_o high 8 cycles, low 4, high 8, low 4, high 8, then low 12 cycles, done_o one cycle, total 44 cycles after the acceptance edge.
REQ-031 SHALL verify pulses=0, gap=2: led_o never high, done_o exactly 8 cycles after acceptance; on/off=0 with pulses=1 yields 4 high cycles.
REQ-032 SHALL verify abort_i pulsed during the 2nd ON phase of a 3-pulse code: led_o = 0 next cycle, code_ready_o = 1, done_o never asserted.
REQ-033 SHALL verify code_valid_i and abort_i high together in IDLE: no acceptance; code_valid_i changing during a code does not alter the timing.
REQ-034 SHALL verify rst_i asserted mid-OFF phase between clock edges: outputs reach reset values before the next edge; valid code after release plays from the start.
REQ-035 SHALL verify code_valid_i held high continuously: second code accepted on the done_o cycle, its first ON phase starts the following cycle.

Source files
------------

// File: rtl/blink_code_ctrl.sv
// rtl/blink_code_ctrl.sv - LED blink-code sequencer: N on pulses with off spacing, then a trailing gap
module blink_code_ctrl #(
  parameter int UNIT_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       code_valid_i,
  output logic       code_ready_o,
  input  logic [3:0] code_pulses_i,
  input  logic [7:0] code_on_i,
  input  logic [7:0] code_off_i,
  input  logic [7:0] code_gap_i,
  input  logic       abort_i,
  output logic       led_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(UNIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    pulses_q, pulses_d;
  logic [7:0]    on_q, on_d;
  logic [7:0]    off_q, off_d;
  logic [7:0]    gap_q, gap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    unit_q, unit_d;
  logic          done_q, done_d;

  logic [7:0]    cur_units;
  logic          phase_end;
  logic          accept;

  // A zero-length field would stall the unit compare, so it plays as one unit.
  function automatic logic [7:0] eff_units(input logic [7:0] u);
    return (u == 8'd0) ? 8'd1 : u;
  endfunction

  // Length of the phase currently playing and its final-clock detect.
  always_comb begin
    cur_units = gap_q;
    case (state_q)
      S_ON:    cur_units = on_q;
      S_OFF:   cur_units = off_q;
      default: cur_units = gap_q;
    endcase
    phase_end = (presc_q == PRESC_MAX) && (unit_q == cur_units - 8'd1);
    accept    = (state_q == S_IDLE) && code_valid_i && !abort_i;
  end

  // Sequencer next state: acceptance, abort, phase advance and timing counters.
  always_comb begin
    state_d  = state_q;
    pulses_d = pulses_q;
    on_d     = on_q;
    off_d    = off_q;
    gap_d    = gap_q;
    presc_d  = presc_q;
    unit_d   = unit_q;
    done_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (accept) begin
        pulses_d = code_pulses_i;
        on_d     = eff_units(code_on_i);
        off_d    = eff_units(code_off_i);
        gap_d    = eff_units(code_gap_i);
        presc_d  = '0;
        unit_d   = 8'd0;
        state_d  = (code_pulses_i != 4'd0) ? S_ON : S_GAP;
      end
    end else if (abort_i) begin
      state_d  = S_IDLE;
      pulses_d = 4'd0;
      presc_d  = '0;
      unit_d   = 8'd0;
    end else if (phase_end) begin
      presc_d = '0;
      unit_d  = 8'd0;
      case (state_q)
        S_ON:  state_d = (pulses_q > 4'd1) ? S_OFF : S_GAP;
        S_OFF: begin
          pulses_d = pulses_q - 4'd1;
          state_d  = S_ON;
        end
        default: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      endcase
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      unit_d  = unit_q + 8'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pulses_q <= 4'd0;
      on_q     <= 8'd0;
      off_q    <= 8'd0;
      gap_q    <= 8'd0;
      presc_q  <= '0;
      unit_q   <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pulses_q <= pulses_d;
      on_q     <= on_d;
      off_q    <= off_d;
      gap_q    <= gap_d;
      presc_q  <= presc_d;
      unit_q   <= unit_d;
      done_q   <= done_d;
    end
  end

  // Outputs decode straight from state so reset drops the LED without a clock.
  always_comb begin
    code_ready_o = (state_q == S_IDLE);
    busy_o       = (state_q != S_IDLE);
    led_o        = (state_q == S_ON);
    done_o       = done_q;
  end

endmodule

// File: tb/tb_blink_code_ctrl.sv
// tb/tb_blink_code_ctrl.sv - directed table-driven bench for blink_code_ctrl
module tb_blink_code_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       code_valid_i;
  logic       code_ready_o;
  logic [3:0] code_pulses_i;
  logic [7:0] code_on_i;
  logic [7:0] code_off_i;
  logic [7:0] code_gap_i;
  logic       abort_i;
  logic       led_o;
  logic       busy_o;
  logic       done_o;

  int checks   = 0;
  int failures = 0;

  blink_code_ctrl #(.UNIT_CYCLES(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .code_valid_i  (code_valid_i),
    .code_ready_o  (code_ready_o),
    .code_pulses_i (code_pulses_i),
    .code_on_i     (code_on_i),
    .code_off_i    (code_off_i),
    .code_gap_i    (code_gap_i),
    .abort_i       (abort_i),
    .led_o         (led_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] p;
    logic [7:0] on;
    logic [7:0] off;
    logic [7:0] gap;
    bit         noise;
    int         done_idx;
    int         high;
    int         rises;
    int         first_low;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!code_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("wait_ready_timeout", int'(code_ready_o), 1);
  endtask

  // Sample index k = k-th falling edge after the acceptance rising edge.
  task automatic play(input logic [3:0] p, input logic [7:0] on, input logic [7:0] off,
                      input logic [7:0] gap, input int exp_done, input bit noise,
                      output int high, output int rises, output int done_idx,
                      output int done_cnt, output int first_low);
    logic prev;
    high = 0; rises = 0; done_idx = -1; done_cnt = 0; first_low = -1; prev = 1'b0;
    code_valid_i = 1'b1; code_pulses_i = p; code_on_i = on; code_off_i = off; code_gap_i = gap;
    for (int idx = 1; idx <= exp_done + 3; idx++) begin
      @(negedge clk_i);
      if (idx == 1) check("busy_after_accept", int'(busy_o), 1);
      if (led_o) high++;
      if (led_o && !prev) rises++;
      if (!led_o && first_low < 0) first_low = idx;
      if (done_o) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
        check("ready_on_done", int'(code_ready_o), 1);
      end
      prev = led_o;
      if (noise && idx < exp_done - 2) begin
        code_valid_i  = 1'($urandom);
        code_pulses_i = 4'($urandom);
        code_on_i     = 8'($urandom);
        code_off_i    = 8'($urandom);
        code_gap_i    = 8'($urandom);
      end else begin
        code_valid_i = 1'b0;
      end
    end
    code_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int high, rises, didx, dcnt, flow;
    wait_ready();
    play(v.p, v.on, v.off, v.gap, v.done_idx, v.noise, high, rises, didx, dcnt, flow);
    check({tag, "_done_idx"}, didx, v.done_idx);
    check({tag, "_done_cnt"}, dcnt, 1);
    check({tag, "_high"}, high, v.high);
    check({tag, "_rises"}, rises, v.rises);
    check({tag, "_first_low"}, flow, v.first_low);
  endtask

  initial begin
    int n;
    int dcnt;
    // {pulses, on, off, gap, noise, done sample, led-high cycles, pulses seen, first low sample}
    vecs[0] = '{4'd3, 8'd2, 8'd1, 8'd3, 1'b0, 45, 24, 3, 9};
    vecs[1] = '{4'd0, 8'd5, 8'd5, 8'd2, 1'b0,  9,  0, 0, 1};
    vecs[2] = '{4'd1, 8'd0, 8'd0, 8'd0, 1'b0,  9,  4, 1, 5};
    vecs[3] = '{4'd2, 8'd1, 8'd0, 8'd1, 1'b1, 17,  8, 2, 5};
    vecs[4] = '{4'd3, 8'd2, 8'd1, 8'd3, 1'b1, 45, 24, 3, 9};

    rst_i = 1'b1; code_valid_i = 1'b0; abort_i = 1'b0;
    code_pulses_i = '0; code_on_i = '0; code_off_i = '0; code_gap_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_led", int'(led_o), 0);
    check("rst_ready", int'(code_ready_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort in the second ON phase (samples 13..20).
    wait_ready();
    code_valid_i = 1'b1; code_pulses_i = 4'd3; code_on_i = 8'd2; code_off_i = 8'd1; code_gap_i = 8'd3;
    for (int idx = 1; idx <= 15; idx++) begin
      @(negedge clk_i);
      code_valid_i = 1'b0;
    end
    check("abort_pre_led", int'(led_o), 1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_led", int'(led_o), 0);
    check("abort_ready", int'(code_ready_o), 1);
    dcnt = 0;
    repeat (60) begin
      @(negedge clk_i);
      if (done_o || led_o) dcnt++;
    end
    check("abort_no_done", dcnt, 0);

    // Valid together with abort in IDLE must not start a code.
    code_valid_i = 1'b1; abort_i = 1'b1; code_pulses_i = 4'd2;
    n = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (busy_o || led_o) n++;
    end
    code_valid_i = 1'b0; abort_i = 1'b0;
    check("valid_abort_idle", n, 0);

    // Async reset mid-OFF (sample 10), then mid-ON.
    code_valid_i = 1'b1; code_pulses_i = 4'd3; code_on_i = 8'd2; code_off_i = 8'd1; code_gap_i = 8'd3;
    for (int idx = 1; idx <= 10; idx++) begin
      @(negedge clk_i);
      code_valid_i = 1'b0;
    end
    check("mid_off_busy", int'(busy_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_ready", int'(code_ready_o), 1);
    check("rst_async_busy", int'(busy_o), 0);
    check("rst_async_done", int'(done_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    code_valid_i = 1'b1;
    for (int idx = 1; idx <= 3; idx++) begin
      @(negedge clk_i);
      code_valid_i = 1'b0;
    end
    check("mid_on_led", int'(led_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_led", int'(led_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("post_rst_idle", int'(busy_o), 0);
    run_vec(vecs[0], "after_rst");

    // Back-to-back with valid held high: 1 pulse, on=1, gap=1 -> done at sample 9.
    wait_ready();
    code_valid_i = 1'b1; code_pulses_i = 4'd1; code_on_i = 8'd1; code_off_i = 8'd1; code_gap_i = 8'd1;
    repeat (9) @(negedge clk_i);
    check("b2b_done", int'(done_o), 1);
    check("b2b_ready", int'(code_ready_o), 1);
    @(negedge clk_i);
    code_valid_i = 1'b0;
    check("b2b_led2", int'(led_o), 1);
    check("b2b_busy2", int'(busy_o), 1);
    check("b2b_done_clear", int'(done_o), 0);
    repeat (8) @(negedge clk_i);
    check("b2b_done2", int'(done_o), 1);
    @(negedge clk_i);
    check("b2b_idle", int'(busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
